// File: rtl/dmem_arbiter.sv
// Shares single-port DataMemory between CPU word accesses and DMA word bursts.
// CPU has priority; per-side streak counters bound how long either side can starve the other.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BLEN_W       = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [BLEN_W-1:0] dma_len,
    output logic              dma_ack,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_wready,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [BLEN_W-1:0] beat_q, beat_d;
    logic [BLEN_W-1:0] len_q, len_d;
    logic [ADDR_W-3:0] base_q, base_d;
    logic              dir_q, dir_d;
    logic [SW-1:0]     cpu_streak_q, cpu_streak_d;
    logic [SW-1:0]     dma_streak_q, dma_streak_d;

    logic              grant_cpu, grant_dma, first_beat, beat_we, beat_last;
    logic [ADDR_W-1:0] beat_addr;
    logic              addr_lo_unused;

    // Bursts are word-aligned; the byte offset of the base is dropped.
    assign addr_lo_unused = ^dma_addr[1:0];

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v >= LIMIT) ? v : v + SW'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        len_d      = len_q;
        base_d     = base_q;
        dir_d      = dir_q;
        grant_cpu  = 1'b0;
        grant_dma  = 1'b0;
        first_beat = 1'b0;
        beat_we    = 1'b0;
        beat_last  = 1'b0;
        beat_addr  = '0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && (!dma_req || cpu_streak_q < LIMIT)) begin
                    grant_cpu = 1'b1;
                end else if (dma_req) begin
                    grant_dma  = 1'b1;
                    first_beat = 1'b1;
                    beat_we    = dma_we;
                    beat_addr  = {dma_addr[ADDR_W-1:2], 2'b00};
                    beat_last  = (dma_len == '0);
                    base_d     = dma_addr[ADDR_W-1:2];
                    len_d      = dma_len;
                    dir_d      = dma_we;
                    beat_d     = BLEN_W'(1);
                    if (!beat_last) state_d = ST_BURST;
                end
            end
            default: begin
                // A CPU slot steals the cycle without advancing the beat index.
                if (cpu_req && dma_streak_q >= LIMIT) begin
                    grant_cpu = 1'b1;
                end else begin
                    grant_dma = 1'b1;
                    beat_we   = dir_q;
                    beat_addr = {base_q + (ADDR_W-2)'(beat_q), 2'b00};
                    beat_last = (beat_q == len_q);
                    beat_d    = beat_q + BLEN_W'(1);
                    if (beat_last) state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        cpu_streak_d = cpu_streak_q;
        if (!dma_req || grant_dma) cpu_streak_d = '0;
        else if (grant_cpu)        cpu_streak_d = sat_inc(cpu_streak_q);

        dma_streak_d = dma_streak_q;
        if (!cpu_req || grant_cpu) dma_streak_d = '0;
        else if (grant_dma)        dma_streak_d = sat_inc(dma_streak_q);
    end

    // Outputs are forced low for the whole time reset is asserted.
    always_comb begin
        cpu_ack    = 1'b0;
        cpu_rdata  = '0;
        dma_ack    = 1'b0;
        dma_wready = 1'b0;
        dma_rvalid = 1'b0;
        dma_rdata  = '0;
        dma_done   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (rst_n) begin
            if (grant_cpu) begin
                cpu_ack   = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                cpu_rdata = cpu_we ? '0 : mem_rdata;
            end else if (grant_dma) begin
                dma_ack    = first_beat;
                mem_we     = beat_we;
                mem_addr   = beat_addr;
                mem_wdata  = beat_we ? dma_wdata : '0;
                dma_wready = beat_we;
                dma_rvalid = !beat_we;
                dma_rdata  = beat_we ? '0 : mem_rdata;
                dma_done   = beat_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            len_q        <= '0;
            base_q       <= '0;
            dir_q        <= 1'b0;
            cpu_streak_q <= '0;
            dma_streak_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            len_q        <= len_d;
            base_q       <= base_d;
            dir_q        <= dir_d;
            cpu_streak_q <= cpu_streak_d;
            dma_streak_q <= dma_streak_d;
        end
    end
endmodule
